// File: rtl/dtfag_agu_param.sv
// dtfag_agu_param: parametrised radix-2^RADIX_LOG2 DIF FFT twiddle address generator; optional inverse exponents under `DTFAG_INV_EN
module dtfag_agu_param #(
  parameter int FFT_LOG2   = 16,
  parameter int RADIX_LOG2 = 4,
  parameter int NUM_MA     = 4,
  localparam int SEG_W  = FFT_LOG2 / NUM_MA,
  localparam int AW     = NUM_MA * SEG_W,
  localparam int STAGES = FFT_LOG2 / RADIX_LOG2,
  localparam int TW     = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int IW     = FFT_LOG2 - RADIX_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef DTFAG_INV_EN
  input  logic                  inv,
`endif
  output logic                  busy,
  output logic                  ma_valid,
  input  logic                  ma_ready,
  output logic [AW-1:0]         ma,
  output logic [TW-1:0]         ma_t,
  output logic [IW-1:0]         ma_i,
  output logic [RADIX_LOG2-1:0] ma_j,
  output logic                  ma_last,
  output logic                  done
);
  if (FFT_LOG2 % RADIX_LOG2 != 0 || FFT_LOG2 % NUM_MA != 0 || RADIX_LOG2 >= FFT_LOG2) begin : g_cfg_err
    $error("dtfag_agu_param: FFT_LOG2 must be an exact multiple of RADIX_LOG2 and NUM_MA, with RADIX_LOG2 < FFT_LOG2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [TW-1:0] t_q, t_d;
  logic [IW-1:0] i_q, i_d, ish;
  logic [RADIX_LOG2-1:0] j_q, j_d;
  logic [FFT_LOG2-1:0] base, e_fwd, e;
  logic jw, iw, tw, is_last, accept, hs, load, fin, inv_eff;
`ifdef DTFAG_INV_EN
  logic inv_q;
  // Inverse select is captured once per run and held until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
  assign inv_eff = accept ? inv : inv_q;
`else
  assign inv_eff = 1'b0;
`endif
  // Counters point at the beat to be loaded next; the exponent is derived from them directly.
  // Shifting i left by RADIX_LOG2*t inside IW bits drops exactly the bits above M, giving (i mod M) << RADIX_LOG2*t
  always_comb begin
    accept  = (state_q == IDLE) && start;
    hs      = (state_q == RUN) && ma_valid && ma_ready;
    load    = accept || (hs && !ma_last);
    fin     = hs && ma_last;
    jw      = &j_q;
    iw      = &i_q;
    tw      = t_q == TW'(STAGES - 1);
    is_last = jw && iw && tw;
    j_d     = j_q + 1'b1;
    i_d     = jw ? i_q + 1'b1 : i_q;
    t_d     = (jw && iw) ? (tw ? '0 : t_q + 1'b1) : t_q;
    ish     = i_q << (RADIX_LOG2 * t_q);
    base    = {{RADIX_LOG2{1'b0}}, ish};
    e_fwd   = base * {{IW{1'b0}}, j_q};
    e       = inv_eff ? -e_fwd : e_fwd;
  end
  // Run-control FSM: start acceptance, valid/busy, and the one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      ma_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= RUN;
            busy     <= 1'b1;
            ma_valid <= 1'b1;
          end
        end
        RUN: if (fin) begin
          state_q  <= DONE;
          busy     <= 1'b0;
          ma_valid <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end
  // Beat register and counters advance only when a new beat is loaded, so stalls freeze everything
  always_ff @(posedge clk) begin
    if (rst) begin
      ma      <= '0;
      ma_t    <= '0;
      ma_i    <= '0;
      ma_j    <= '0;
      ma_last <= 1'b0;
      t_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else if (load) begin
      ma      <= AW'(e);
      ma_t    <= t_q;
      ma_i    <= i_q;
      ma_j    <= j_q;
      ma_last <= is_last;
      t_q     <= t_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end else if (fin) begin
      ma_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dtfag_agu_param.sv
// tb_dtfag_agu_param: randomized self-checking bench for dtfag_agu_param at N=256, R=4
module tb_dtfag_agu_param;
  localparam int FL = 8, RL = 2, NM = 4, N = 256, R = 4, ST = 4, BF = 64, TOTAL = ST * N;
  logic clk = 1'b0;
  logic rst, start, inv, ma_ready;
  logic busy, ma_valid, ma_last, done;
  logic [7:0] ma;
  logic [1:0] ma_t;
  logic [5:0] ma_i;
  logic [1:0] ma_j;
  int n_cmp = 0, n_err = 0;
  bit inv_m = 1'b0;

  dtfag_agu_param #(.FFT_LOG2(FL), .RADIX_LOG2(RL), .NUM_MA(NM)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef DTFAG_INV_EN
    .inv(inv),
`endif
    .busy(busy), .ma_valid(ma_valid), .ma_ready(ma_ready), .ma(ma),
    .ma_t(ma_t), .ma_i(ma_i), .ma_j(ma_j), .ma_last(ma_last), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_beat(input int k);
    int t, i, j, m, e;
    t = k / (R * BF);
    i = (k % (R * BF)) / R;
    j = k % R;
    m = N >> (RL * (t + 1));
    e = (j * ((i % m) << (RL * t))) % N;
    if (inv_m) e = (N - e) % N;
    return {2'(t), 6'(i), 2'(j), 8'(e), 1'(k == TOTAL - 1)};
  endfunction

  task automatic do_run(input bit rnd, input bit pulses, input int rst_at, input bit inv_v);
    int k = 0, busy_n = 0;
    bit stall = 0, last_hs = 0, fin = 0;
    logic [18:0] held = '0, got, exp;
    inv_m = inv_v;
    inv = inv_v;
    start = 1'b1;
    ma_ready = 1'b1;
    for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      got = {ma_t, ma_i, ma_j, ma, ma_last};
      if (cyc == 0) begin
        n_cmp++;
        if (ma_valid !== 1'b1 || busy !== 1'b1) begin
          n_err++; $display("FAIL first_beat valid=%b busy=%b required 1 1", ma_valid, busy);
        end
      end
      if (busy) busy_n++;
      if (last_hs) begin
        n_cmp++;
        if ({done, busy, ma_valid} !== 3'b100) begin
          n_err++; $display("FAIL done_cycle done/busy/valid=%b required 100", {done, busy, ma_valid});
        end
        if (pulses) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({done, busy, ma_valid} !== 3'b000) begin
          n_err++; $display("FAIL after_done done/busy/valid=%b required 000", {done, busy, ma_valid});
        end
        if (!rnd) begin
          n_cmp++;
          if (busy_n != TOTAL) begin
            n_err++; $display("FAIL busy_len got %0d required %0d", busy_n, TOTAL);
          end
        end
        n_cmp++;
        if (k != TOTAL) begin
          n_err++; $display("FAIL beat_count got %0d required %0d", k, TOTAL);
        end
        fin = 1;
      end else begin
        if (stall) begin
          n_cmp++;
          if (got !== held) begin
            n_err++; $display("FAIL stall_hold beat %0d got %h required %h", k, got, held);
          end
        end
        exp = exp_beat(k);
        n_cmp++;
        if (ma_valid !== 1'b1 || got !== exp) begin
          n_err++; $display("FAIL beat %0d valid=%b t/i/j/ma/last got %h required %h", k, ma_valid, got, exp);
        end
        if (!inv_v && (k == 23 || k == 342)) begin
          n_cmp++;
          if (ma !== (k == 23 ? 8'h0F : 8'h28)) begin
            n_err++; $display("FAIL spot_value beat %0d ma=%h required %h", k, ma, (k == 23 ? 8'h0F : 8'h28));
          end
        end
        if (inv_v && (k < 4 || k == 5)) begin
          n_cmp++;
          if (ma !== (k == 5 ? 8'hFF : 8'h00)) begin
            n_err++; $display("FAIL inv_value beat %0d ma=%h required %h", k, ma, (k == 5 ? 8'hFF : 8'h00));
          end
        end
        if (k == rst_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          n_cmp++;
          if ({busy, ma_valid, ma, ma_t, ma_i, ma_j, ma_last, done} !== '0) begin
            n_err++; $display("FAIL mid_reset outputs=%h required 0", {busy, ma_valid, ma, ma_t, ma_i, ma_j, ma_last, done});
          end
          for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({done, busy, ma_valid} !== 3'b000) begin
              n_err++; $display("FAIL post_reset_idle done/busy/valid=%b required 000", {done, busy, ma_valid});
            end
          end
          fin = 1;
        end else begin
          ma_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (pulses && (k == 10 || k == 500)) start = 1'b1;
          stall = ma_valid && !ma_ready;
          held = got;
          if (ma_valid && ma_ready) begin
            last_hs = (k == TOTAL - 1);
            k++;
          end
        end
      end
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL timeout run ended at beat %0d required %0d", k, TOTAL);
    end
    start = 1'b0;
    ma_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inv = 1'b0; ma_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, ma_valid, ma, ma_t, ma_i, ma_j, ma_last, done} !== '0) begin
      n_err++; $display("FAIL reset outputs=%h required 0", {busy, ma_valid, ma, ma_t, ma_i, ma_j, ma_last, done});
    end
  endtask

  task automatic test_full_run();
    do_run(1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random_ready();
    do_run(1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_run(1'b0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    do_run(1'b1, 1'b0, 300, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b0);
  endtask

`ifdef DTFAG_INV_EN
  task automatic test_inverse();
    do_run(1'b1, 1'b0, -1, 1'b1);
    do_run(1'b0, 1'b0, -1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_random_ready();
    test_start_ignored();
    test_reset_mid_run();
`ifdef DTFAG_INV_EN
    test_inverse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dtfag_agu_param.md
Name: dtfag_agu_param

Overview:
- Parametrised twiddle-factor address generator; successor to the fixed radix-16 / 65536-point DTFAG AGU.
- Walks every (stage t, butterfly i, twiddle j) triple of a radix-2^RADIX_LOG2 DIF FFT of size 2^FFT_LOG2.
- Emits one twiddle exponent per handshake, split into NUM_MA sub-ROM addresses (MA0..MA(NUM_MA-1)).
- Sits between the FFT controller (start/done) and the banked twiddle ROMs (valid/ready).

Parameters:
FFT_LOG2, 16, log2 of FFT size N
RADIX_LOG2, 4, log2 of radix R
NUM_MA, 4, number of sub-ROM address fields; SEG_W = FFT_LOG2/NUM_MA
Derived: STAGES = FFT_LOG2/RADIX_LOG2; BF = N/R; elaboration error unless both divisions are exact.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle run request
inv  in  1  inverse-transform select, sampled with start (only when DTFAG_INV_EN defined)
busy  out  1  run in progress
ma_valid  out  1  address beat valid
ma_ready  in  1  downstream accepts beat
ma  out  NUM_MA*SEG_W  packed addresses, MAm = ma[m*SEG_W +: SEG_W]
ma_t  out  clog2(STAGES) (min 1)  stage of current beat
ma_i  out  FFT_LOG2-RADIX_LOG2  butterfly index of current beat
ma_j  out  RADIX_LOG2  twiddle index of current beat
ma_last  out  1  final beat of run
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: busy, ma_valid, ma, ma_t, ma_i, ma_j, ma_last, done all 0; counters 0; FSM IDLE.
- Reset has priority over every other input, including mid-run; the run is abandoned with no done pulse.
- FSM IDLE -> RUN: start=1 in IDLE. busy=1 from the next cycle; the first beat (t=0, i=0, j=0) has ma_valid=1 in that same cycle.
- start in RUN or DONE: ignored.
- Iteration order: j fastest (0..R-1), then i (0..BF-1), then t (0..STAGES-1). Total beats = STAGES*N.
- Exponent per beat:
  - M = N >> (RADIX_LOG2*(t+1)).
  - e = (j * ((i mod M) << (RADIX_LOG2*t))) mod N, computed to FFT_LOG2 bits.
  - Final stage (M=1) always gives e=0.
  - MAm = e[m*SEG_W +: SEG_W].
- Output register: loads the next beat when !ma_valid || ma_ready.
- Backpressure: while ma_valid && !ma_ready, all ma* outputs hold stable and counters freeze.
- ma_last=1 only on the beat t=STAGES-1, i=BF-1, j=R-1.
- RUN -> DONE: handshake of the ma_last beat. In the next cycle ma_valid=0, busy=0, done=1 for one cycle, then IDLE.
- A start asserted in the done cycle is ignored; start is accepted again from the following IDLE cycle.
- Counters wrap to 0 at the end of each field. No other wrap is legal.

Optional Feature:
- Macro: DTFAG_INV_EN.
- Defined: inv port exists and is latched on an accepted start. When latched 1, every beat uses e' = (N - e) mod N, so e=0 stays 0. Latched value is held for the whole run.
- Not defined: inv port absent; forward exponents only.

Test Plan:
All scenarios use FFT_LOG2=8, RADIX_LOG2=2, NUM_MA=4 (N=256, R=4, STAGES=4, BF=64, SEG_W=2).
- Full run, ma_ready=1: start -> exactly 1024 beats on consecutive cycles; first beat appears the cycle after start; ma_last on beat 1023; done one cycle later; busy high for exactly 1024 cycles.
- Value check: t=0,i=5,j=3 -> e=15 -> MA0=3, MA1=3, MA2=0, MA3=0. t=1,i=21,j=2 -> e=40 -> MA0=0, MA1=2, MA2=2, MA3=0. Every t=3 beat -> ma=0.
- Random ma_ready (50%): beat sequence identical to the stalled-free run; outputs stable during every stall; no beat dropped or duplicated.
- start pulsed at beats 10 and 500, and in the done cycle -> no effect; beat count stays 1024.
- rst asserted at beat 300 -> next cycle all outputs 0, no done pulse; a new start restarts at t=0, i=0, j=0.
- DTFAG_INV_EN, inv=1: t=0,i=1,j=1 -> ma=all 3s (e=255); t=0,i=0 beats -> ma=0. Macro undefined -> port absent, build clean.
